// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - amode constants, length decode and FSM states for ifetch_queue
// IFQ_BUSERR_EN adds the HALT state used to stop fetching after a bus error.
package ifq_pkg;

    localparam logic [2:0] AMODE_16 = 3'b000;
    localparam logic [2:0] AMODE_32 = 3'b001;
    localparam logic [2:0] AMODE_48 = 3'b010;

`ifdef IFQ_BUSERR_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_HALT = 2'd2} ifq_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1} ifq_state_e;
`endif

    // Instruction length in halfwords, taken from the head halfword's amode field.
    function automatic logic [1:0] ifq_len(input logic [15:0] hw);
        case (hw[3:1])
            AMODE_16: ifq_len = 2'd1;
            AMODE_32: ifq_len = 2'd2;
            AMODE_48: ifq_len = 2'd3;
            default:  ifq_len = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - Wishbone read-master bus bundle for ifetch_queue
// Signal names keep the master's point of view (o_ = driven by the fetch unit).
interface ifetch_queue_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] o_wb_addr;
    logic              o_wb_cyc;
    logic [3:0]        o_wb_stb;
    logic              o_wb_we;
    logic [31:0]       o_wb_dat;
    logic [31:0]       i_wb_dat;
    logic              i_wb_ack;
    logic              i_wb_err;

    modport master (
        output o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_dat,
        input  i_wb_dat, i_wb_ack, i_wb_err
    );

    modport slave (
        input  o_wb_addr, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_dat,
        output i_wb_dat, i_wb_ack, i_wb_err
    );
endinterface

// File: rtl/ifq_hwbuf.sv
// rtl/ifq_hwbuf.sv - circular halfword queue: up to 2 writes and a 3-halfword read window per cycle
module ifq_hwbuf #(
    parameter int DEPTH_HW = 8,
    localparam int PTR_W = $clog2(DEPTH_HW),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [1:0]       wr_n_i,
    input  logic [15:0]      wr_hw0_i,
    input  logic [15:0]      wr_hw1_i,
    input  logic [1:0]       rd_n_i,
    output logic [47:0]      rd_win_o,
    output logic [CNT_W-1:0] count_o
);

    logic [15:0]      mem_q [DEPTH_HW];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] wptr_p1, rptr_p1, rptr_p2;

    assign wptr_p1 = wptr_q + PTR_W'(1);
    assign rptr_p1 = rptr_q + PTR_W'(1);
    assign rptr_p2 = rptr_q + PTR_W'(2);

    // Storage is not reset: consumers only look at it through the occupancy count.
    always_ff @(posedge clk_i) begin
        if (wr_n_i != 2'd0) mem_q[wptr_q]  <= wr_hw0_i;
        if (wr_n_i == 2'd2) mem_q[wptr_p1] <= wr_hw1_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + PTR_W'(wr_n_i);
            rptr_q  <= rptr_q + PTR_W'(rd_n_i);
            count_q <= count_q + CNT_W'(wr_n_i) - CNT_W'(rd_n_i);
        end
    end

    assign rd_win_o = {mem_q[rptr_q], mem_q[rptr_p1], mem_q[rptr_p2]};
    assign count_o  = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue: Wishbone fetch FSM feeding a halfword queue
// IFQ_BUSERR_EN: bus error halts fetching and raises o_error instead of retrying.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH_HW = 8,
    parameter int ADDR_W   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    ifetch_queue_if.master    wb,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [47:0]       o_instruction,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_error
);

    localparam int PTR_W = $clog2(DEPTH_HW);
    localparam int CNT_W = PTR_W + 1;

    ifq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count, free;
    logic [47:0]       win;
    logic [1:0]        head_len, need, wr_n, rd_n;
    logic              in_req, ack_ok;

    assign in_req   = (state_q == ST_REQ);
    assign need     = faddr_q[1] ? 2'd1 : 2'd2;
    assign free     = CNT_W'(DEPTH_HW) - count;
    assign head_len = ifq_len(win[47:32]);

    // A redirect in the same cycle as ack/err throws the returned data away.
    assign ack_ok = in_req & wb.i_wb_ack & ~i_redirect;
    assign wr_n   = ack_ok ? need : 2'd0;
    assign rd_n   = (o_valid & i_ready & ~i_redirect) ? head_len : 2'd0;

    ifq_hwbuf #(.DEPTH_HW(DEPTH_HW)) u_hwbuf (
        .clk_i    (i_clk),
        .rst_i    (i_reset),
        .flush_i  (i_redirect),
        .wr_n_i   (wr_n),
        .wr_hw0_i (faddr_q[1] ? wb.i_wb_dat[15:0] : wb.i_wb_dat[31:16]),
        .wr_hw1_i (wb.i_wb_dat[15:0]),
        .rd_n_i   (rd_n),
        .rd_win_o (win),
        .count_o  (count)
    );

    always_comb begin
        state_d = state_q;
        faddr_d = faddr_q;
        if (i_redirect) begin
            state_d = ST_IDLE;
            faddr_d = i_pc;
        end else begin
            case (state_q)
                ST_IDLE: if (free >= CNT_W'(need)) state_d = ST_REQ;
                ST_REQ: begin
                    if (wb.i_wb_ack) begin
                        faddr_d = faddr_q + ADDR_W'({need, 1'b0});
                        state_d = ST_IDLE;
                    end else if (wb.i_wb_err) begin
`ifdef IFQ_BUSERR_EN
                        state_d = ST_HALT;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
`ifdef IFQ_BUSERR_EN
                ST_HALT: state_d = ST_HALT;
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign pc_d = i_redirect ? i_pc : pc_q + ADDR_W'({rd_n, 1'b0});

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            faddr_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            faddr_q <= faddr_d;
            pc_q    <= pc_d;
        end
    end

    assign wb.o_wb_cyc  = in_req;
    assign wb.o_wb_stb  = in_req ? (faddr_q[1] ? 4'b0011 : 4'b1111) : 4'b0000;
    assign wb.o_wb_addr = in_req ? {faddr_q[ADDR_W-1:2], 2'b00} : '0;
    assign wb.o_wb_we   = 1'b0;
    assign wb.o_wb_dat  = 32'h0;

    assign o_valid = (count >= CNT_W'(head_len));
    assign o_pc    = pc_q;

    always_comb begin
        o_instruction = 48'h0;
        if (o_valid) begin
            case (head_len)
                2'd2:    o_instruction = {win[47:16], 16'h0};
                2'd3:    o_instruction = win;
                default: o_instruction = {win[47:32], 32'h0};
            endcase
        end
    end

`ifdef IFQ_BUSERR_EN
    assign o_error = (state_q == ST_HALT) & ~o_valid;
`else
    assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue with a zero-wait memory model
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_redirect;
    logic [31:0] i_pc;
    logic        i_ready;
    logic        o_valid;
    logic [47:0] o_instruction;
    logic [31:0] o_pc;
    logic        o_error;
    logic        err_force;

    int checks = 0;
    int errors = 0;

    ifetch_queue_if #(.ADDR_W(32)) wb ();

    ifetch_queue #(.DEPTH_HW(8), .ADDR_W(32)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .wb            (wb),
        .i_redirect    (i_redirect),
        .i_pc          (i_pc),
        .i_ready       (i_ready),
        .o_valid       (o_valid),
        .o_instruction (o_instruction),
        .o_pc          (o_pc),
        .o_error       (o_error)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_rd = 32'h1230_1234;
            32'h0000_0104: mem_rd = 32'h5678_9AB0;
            32'h0000_0108: mem_rd = 32'h0002_0000;
            32'h0000_0200: mem_rd = 32'hC0DE_0000;
            default:       mem_rd = 32'h0000_0000;
        endcase
    endfunction

    assign wb.i_wb_dat = mem_rd(wb.o_wb_addr);
    assign wb.i_wb_ack = wb.o_wb_cyc & ~err_force;
    assign wb.i_wb_err = wb.o_wb_cyc & err_force;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        i_redirect = 1'b1;
        i_pc       = pc;
        tick();
        i_redirect = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int  acks;
        logic seen;
        i_reset    = 1'b0;
        i_redirect = 1'b0;
        i_pc       = 32'h0;
        i_ready    = 1'b0;
        err_force  = 1'b0;
        #1 i_reset = 1'b1;
        #1;
        check_eq("rst_cyc",   wb.o_wb_cyc,   1'b0);
        check_eq("rst_stb",   wb.o_wb_stb,   4'h0);
        check_eq("rst_addr",  wb.o_wb_addr,  32'h0);
        check_eq("rst_valid", o_valid,       1'b0);
        check_eq("rst_error", o_error,       1'b0);
        check_eq("rst_pc",    o_pc,          32'h0);
        check_eq("rst_instr", o_instruction, 48'h0);
        tick();
        tick();
        check_eq("rst_hold_cyc", wb.o_wb_cyc, 1'b0);
        i_reset = 1'b0;
        tick();
        check_eq("boot_cyc",  wb.o_wb_cyc,  1'b1);
        check_eq("boot_addr", wb.o_wb_addr, 32'h0);
        check_eq("boot_we",   wb.o_wb_we,   1'b0);
        check_eq("boot_dat",  wb.o_wb_dat,  32'h0);

        // 16-bit instruction at 0x100, then a 48-bit one at 0x102
        do_redirect(32'h100);
        check_eq("a_valid0", o_valid,     1'b0);
        check_eq("a_cyc0",   wb.o_wb_cyc, 1'b0);
        tick();
        check_eq("a_addr",   wb.o_wb_addr, 32'h100);
        check_eq("a_stb",    wb.o_wb_stb,  4'hF);
        tick();
        check_eq("a_valid",  o_valid,       1'b1);
        check_eq("a_instr",  o_instruction, 48'h1230_0000_0000);
        check_eq("a_pc",     o_pc,          32'h100);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check_eq("a_pc_pop", o_pc,    32'h102);
        check_eq("a_valid1", o_valid, 1'b0);
        tick();
        check_eq("a_valid2", o_valid,       1'b1);
        check_eq("a_instr2", o_instruction, 48'h1234_5678_9AB0);

        // Unaligned start: half access, then aligned continuation
        do_redirect(32'h102);
        tick();
        check_eq("b_stb",    wb.o_wb_stb,  4'h3);
        check_eq("b_addr",   wb.o_wb_addr, 32'h100);
        tick();
        check_eq("b_valid0", o_valid, 1'b0);
        tick();
        check_eq("b_addr2",  wb.o_wb_addr, 32'h104);
        check_eq("b_stb2",   wb.o_wb_stb,  4'hF);
        tick();
        check_eq("b_valid",  o_valid,       1'b1);
        check_eq("b_instr",  o_instruction, 48'h1234_5678_9AB0);
        check_eq("b_pc",     o_pc,          32'h102);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check_eq("b_pc_pop", o_pc, 32'h108);

        // Consumer stalled: queue fills after four aligned accesses
        do_redirect(32'h100);
        acks = 0;
        for (int i = 0; i < 24; i++) begin
            if (wb.o_wb_cyc && wb.i_wb_ack) acks++;
            tick();
        end
        check_eq("c_acks",  acks,        4);
        check_eq("c_cyc",   wb.o_wb_cyc, 1'b0);
        check_eq("c_valid", o_valid,     1'b1);
        i_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (wb.o_wb_cyc) seen = 1'b1;
        end
        i_ready = 1'b0;
        check_eq("c_resume", seen, 1'b1);

        // Redirect coincident with ack
        do_redirect(32'h100);
        tick();
        check_eq("d_cyc_ack", wb.o_wb_cyc & wb.i_wb_ack, 1'b1);
        do_redirect(32'h200);
        check_eq("d_valid0", o_valid,     1'b0);
        check_eq("d_cyc0",   wb.o_wb_cyc, 1'b0);
        check_eq("d_pc",     o_pc,        32'h200);
        tick();
        check_eq("d_addr",   wb.o_wb_addr, 32'h200);
        tick();
        check_eq("d_valid",  o_valid,       1'b1);
        check_eq("d_instr",  o_instruction, 48'hC0DE_0000_0000);

        // Bus error on the second access of a 48-bit instruction
        do_redirect(32'h102);
        tick();
        tick();
        err_force = 1'b1;
        tick();
        check_eq("e_addr_err", wb.o_wb_addr, 32'h104);
        tick();
        check_eq("e_valid", o_valid,     1'b0);
        check_eq("e_cyc",   wb.o_wb_cyc, 1'b0);
`ifdef IFQ_BUSERR_EN
        check_eq("e_error", o_error, 1'b1);
        tick();
        tick();
        tick();
        check_eq("e_halt_cyc", wb.o_wb_cyc, 1'b0);
        err_force = 1'b0;
        do_redirect(32'h100);
        check_eq("e_error_clr", o_error, 1'b0);
`else
        check_eq("e_error", o_error, 1'b0);
        tick();
        check_eq("e_retry_cyc",  wb.o_wb_cyc,  1'b1);
        check_eq("e_retry_addr", wb.o_wb_addr, 32'h104);
        err_force = 1'b0;
        tick();
        check_eq("e_valid2", o_valid,       1'b1);
        check_eq("e_instr2", o_instruction, 48'h1234_5678_9AB0);
`endif

        // Fetch address wraps past the top of the address space
        do_redirect(32'hFFFF_FFFC);
        tick();
        check_eq("f_addr", wb.o_wb_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        check_eq("f_cyc_wrap",  wb.o_wb_cyc,  1'b1);
        check_eq("f_addr_wrap", wb.o_wb_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH_HW, default 8, meaning queue depth in halfwords (power of 2, 4..64).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-003 SHALL have port i_clk  in  1  the single clock; all state on rising edge.
REQ-004 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports o_wb_addr out ADDR_W, o_wb_cyc out 1, o_wb_stb out 4 (byte lanes), o_wb_we out 1, o_wb_dat out 32, i_wb_dat in 32, i_wb_ack in 1, i_wb_err in 1; Wishbone read master.
REQ-006 SHALL have ports i_redirect in 1 (flush, restart at i_pc) and i_pc in ADDR_W (halfword aligned).
REQ-007 SHALL have ports i_ready in 1 (consumer accepts), o_valid out 1, o_instruction out 48 (left-aligned), o_pc out ADDR_W (address of o_instruction), o_error out 1.

Function
REQ-008 SHALL hold fetched halfwords in a circular queue of DEPTH_HW entries; read/write pointers wrap modulo DEPTH_HW; occupancy counter 0..DEPTH_HW.
REQ-009 SHALL run fetch FSM IDLE -> REQ -> IDLE; REQ holds o_wb_cyc=1 until i_wb_ack or i_wb_err; o_wb_we=0, o_wb_dat=0 always.
REQ-010 SHALL enter REQ from IDLE when free entries >= halfwords the next access delivers (2 aligned, 1 unaligned).
REQ-011 SHALL on fetch address bit1=1 drive o_wb_stb=0011 and push i_wb_dat[15:0]; otherwise stb=1111 and push [31:16] then [15:0]; o_wb_addr = fetch address with bits[1:0]=0.
REQ-012 SHALL advance fetch address by 2 after unaligned, 4 after aligned access; wraps modulo 2^ADDR_W.
REQ-013 SHALL decode length from head halfword bits[3:1] (amode): 000 -> 1 halfword, 001 -> 2, 010 -> 3, others -> 1.
REQ-014 SHALL assert o_valid combinationally from registered state when occupancy >= decoded length, with o_instruction = head halfwords, unused low halfwords zero.
REQ-015 SHALL on o_valid && i_ready pop length halfwords and advance o_pc by 2*length in the same edge.
REQ-016 SHALL support simultaneous push and pop in one cycle; occupancy += pushed - popped.
REQ-017 SHALL on i_redirect empty the queue, drop o_wb_cyc at that edge, load fetch address and o_pc from i_pc, discard any ack/err in that same cycle; o_valid low next cycle.
REQ-018 SHALL give redirect priority over ack, err and pop in the same cycle.
REQ-019 SHALL with zero-wait slave reach o_valid 2 cycles after redirect for an aligned 16- or 32-bit instruction.
REQ-020 SHALL never push into a full queue; stalls in IDLE while i_ready=0 and queue full.

Reset
REQ-021 SHALL asynchronously clear: o_wb_cyc, o_wb_stb, o_wb_addr, o_valid, o_error, o_pc, o_instruction, pointers, occupancy to 0; FSM to IDLE; fetch address 0.
REQ-022 SHALL begin fetching at address 0 after reset deassertion; reset mid-cycle abandons the bus cycle immediately.

Configuration
REQ-023 SHALL honour macro IFQ_BUSERR_EN: defined -> i_wb_err ends cycle, FSM enters HALT, no further fetches, o_error=1 when halted and occupancy < decoded length (or queue empty), cleared by redirect/reset.
REQ-024 SHALL without IFQ_BUSERR_EN retry the same address after i_wb_err; HALT state absent; o_error tied 0.

Structure
REQ-025 SHALL place amode constants, length-decode function and FSM state type in shared package ifq_pkg.
REQ-026 SHALL implement storage as sub-module ifq_hwbuf (up to 2-halfword write, 3-halfword read window).

Verification
REQ-027 Redirect to 0x100, zero-wait memory, amode 000 at 0x100 -> o_valid at cycle 2, o_instruction[47:32]=mem, o_pc=0x100; next pop o_pc=0x102.
REQ-028 Redirect to 0x102, 48-bit instruction -> first access stb=0011 addr 0x100, next addr 0x104; o_valid with all 3 halfwords, then o_pc=0x108.
REQ-029 i_ready=0, DEPTH_HW=8 -> exactly 4 aligned accesses, then o_wb_cyc stays 0; raise i_ready -> fetching resumes.
REQ-030 Redirect in same cycle as i_wb_ack -> data discarded, queue empty, next o_wb_addr = new i_pc.
REQ-031 IFQ_BUSERR_EN, err on second access of 48-bit instruction -> o_error=1, o_valid=0, no further cycles; redirect clears o_error. Without macro -> same address reissued.
REQ-032 Fetch at 0xFFFFFFFC -> next o_wb_addr 0x00000000.
